// File: rtl/down_counter_underflow_if.sv
// Control/status bundle for the loadable down-counter: the master drives
// the load/count controls and the slave (the counter) returns count and underflow status.
interface down_counter_underflow_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic             clear_underflow;
  logic [WIDTH-1:0] counter_out;
  logic             underflow_out;
  logic             underflow_pulse;
  logic             busy_out;

  modport master (
    output enable, load, load_value, auto_reload, clear_underflow,
    input  counter_out, underflow_out, underflow_pulse, busy_out
  );

  modport slave (
    input  enable, load, load_value, auto_reload, clear_underflow,
    output counter_out, underflow_out, underflow_pulse, busy_out
  );
endinterface

// File: rtl/down_counter_underflow.sv
// Loadable down-counter with an underflow pulse, a sticky underflow flag and
// one-shot or auto-reload operation. All outputs come straight from flops.
module down_counter_underflow #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  down_counter_underflow_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             flag_q;
  logic             pulse_q;
  logic             busy_q;

  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in the block override the earlier defaults on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      flag_q   <= 1'b0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (bus.clear_underflow) begin
        flag_q <= 1'b0;
      end

      if (bus.load) begin
        // Load beats both counting and underflow detection.
        count_q  <= bus.load_value;
        reload_q <= bus.load_value;
        state    <= RUN;
        busy_q   <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (bus.enable) begin
              if (count_q != '0) begin
                count_q <= count_q - WIDTH'(1);
              end else begin
                // Underflow event: setting the flag wins over a coincident clear.
                pulse_q <= 1'b1;
                flag_q  <= 1'b1;
                if (bus.auto_reload) begin
                  count_q <= reload_q;
                end else begin
                  state  <= EXPIRED;
                  busy_q <= 1'b0;
                end
              end
            end
          end
          IDLE, EXPIRED: begin
            count_q <= count_q;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.counter_out     = count_q;
  assign bus.underflow_out   = flag_q;
  assign bus.underflow_pulse = pulse_q;
  assign bus.busy_out        = busy_q;

endmodule
